// File: rtl/mem_arbiter_if.sv
// Bus bundle between three requesters, the arbiter and the ROM.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives requests and supplies ROM data (requesters plus ROM model).
`timescale 1ns/1ps
interface mem_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic [2:0]    req;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [AW-1:0] addr2;
  logic [2:0]    gnt;
  logic [2:0]    rvalid;
  logic [DW-1:0] rdata;
  logic          err;
  logic          busy;
  logic          mem_cs;
  logic [AW-2:0] mem_addr;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req, addr0, addr1, addr2, mem_rdata,
    output gnt, rvalid, rdata, err, busy, mem_cs, mem_addr
  );

  modport master (
    output req, addr0, addr1, addr2, mem_rdata,
    input  gnt, rvalid, rdata, err, busy, mem_cs, mem_addr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Three-requester ROM read arbiter (fetch, operand, debug).
// One access in flight at a time: IDLE (grant) -> ADDR (ROM cycle) -> RESP.
// Addresses with the top bit clear are outside the ROM: no chip select is
// raised, the returned word is zero and err accompanies rvalid.
// Optional feature: define ARB_ROUND_ROBIN_EN for rotating priority; without
// it, fixed priority fetch > operand > debug and no pointer register exists.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input logic           clk,
  input logic           rstn,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [1:0]    r_owner;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_rdata;
  logic [1:0]    w_winner;
  logic          w_anyReq;
  logic          w_grantNow;
  logic [AW-1:0] w_selAddr;

  assign w_anyReq   = |bus.req;
  assign w_grantNow = (r_state == IDLE) && w_anyReq && rstn;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] r_rrPtr;

  // Rotating search starting one past the most recently granted requester
  always_comb begin
    w_winner = 2'd0;
    case (r_rrPtr)
      2'd0: begin
        if (bus.req[1])      w_winner = 2'd1;
        else if (bus.req[2]) w_winner = 2'd2;
        else                 w_winner = 2'd0;
      end
      2'd1: begin
        if (bus.req[2])      w_winner = 2'd2;
        else if (bus.req[0]) w_winner = 2'd0;
        else                 w_winner = 2'd1;
      end
      default: begin
        if (bus.req[0])      w_winner = 2'd0;
        else if (bus.req[1]) w_winner = 2'd1;
        else                 w_winner = 2'd2;
      end
    endcase
  end

  // Pointer remembers the last winner and moves only when a grant is issued
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rrPtr <= 2'd2;
    end else if (w_grantNow) begin
      r_rrPtr <= w_winner;
    end
  end
`else
  // Fixed priority: fetch beats operand beats debug
  always_comb begin
    w_winner = 2'd0;
    if (bus.req[0])      w_winner = 2'd0;
    else if (bus.req[1]) w_winner = 2'd1;
    else if (bus.req[2]) w_winner = 2'd2;
    else                 w_winner = 2'd0;
  end
`endif

  // Address of the current winner, taken from its own address bus
  always_comb begin
    w_selAddr = bus.addr0;
    case (w_winner)
      2'd1:    w_selAddr = bus.addr1;
      2'd2:    w_selAddr = bus.addr2;
      default: w_selAddr = bus.addr0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and per-state outputs; everything not driven in a state stays 0
  always_comb begin
    w_nextState  = r_state;
    bus.gnt      = 3'b000;
    bus.rvalid   = 3'b000;
    bus.err      = 1'b0;
    bus.mem_cs   = 1'b0;
    bus.mem_addr = '0;
    case (r_state)
      IDLE: begin
        if (w_grantNow) begin
          bus.gnt     = 3'b001 << w_winner;
          w_nextState = ADDR;
        end
      end
      ADDR: begin
        bus.mem_cs   = r_addr[AW-1];
        bus.mem_addr = r_addr[AW-2:0];
        w_nextState  = RESP;
      end
      RESP: begin
        bus.rvalid  = 3'b001 << r_owner;
        bus.err     = ~r_addr[AW-1];
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Latch owner and its address at grant so later address changes are ignored
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_owner <= 2'd0;
      r_addr  <= '0;
    end else if (w_grantNow) begin
      r_owner <= w_winner;
      r_addr  <= w_selAddr;
    end
  end

  // Capture ROM data at the end of the address cycle; out-of-range reads give 0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rdata <= '0;
    end else if (r_state == ADDR) begin
      r_rdata <= r_addr[AW-1] ? bus.mem_rdata : '0;
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.busy  = (r_state != IDLE);

endmodule
